// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: FSM states, opcodes, shifter
// commands and amount-mux selects.
package shift_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_WB    = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [2:0] SH_SLL  = 3'b000;
  localparam logic [2:0] SH_SRL  = 3'b001;
  localparam logic [2:0] SH_SRA  = 3'b010;
  localparam logic [2:0] SH_SLLV = 3'b011;
  localparam logic [2:0] SH_SRAV = 3'b100;
  localparam logic [2:0] SH_LUI  = 3'b101;

  localparam logic [2:0] CMD_HOLD = 3'b000;
  localparam logic [2:0] CMD_LOAD = 3'b001;
  localparam logic [2:0] CMD_SLL  = 3'b010;
  localparam logic [2:0] CMD_SRL  = 3'b011;
  localparam logic [2:0] CMD_SRA  = 3'b100;

  localparam logic [1:0] AMT_REGB  = 2'b00;
  localparam logic [1:0] AMT_SHAMT = 2'b01;
  localparam logic [1:0] AMT_16    = 2'b10;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/control bundle between the main control unit, the shift datapath
// and the shift sequencer.
interface shift_sequencer_if;
  logic       start;
  logic [2:0] op;
  logic [4:0] amt;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] amt_sel;
  logic       src_sel;
  logic [2:0] shift_cmd;
  logic       res_wr;

  modport master (
    output start, op, amt,
    input  busy, done, err, amt_sel, src_sel, shift_cmd, res_wr
  );

  modport slave (
    input  start, op, amt,
    output busy, done, err, amt_sel, src_sel, shift_cmd, res_wr
  );
endinterface

// File: rtl/shift_op_decode.sv
// Combinational opcode decode: amount-mux select, source select, shift
// direction command and illegal-opcode flag.
module shift_op_decode
  import shift_sequencer_pkg::*;
(
  input  logic [2:0] op,
  output logic [1:0] amt_sel,
  output logic       src_sel,
  output logic [2:0] shift_kind,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    amt_sel    = AMT_SHAMT;
    src_sel    = 1'b0;
    shift_kind = CMD_SLL;
    illegal    = 1'b0;
    case (op)
      SH_SLL:  shift_kind = CMD_SLL;
      SH_SRL:  shift_kind = CMD_SRL;
      SH_SRA:  shift_kind = CMD_SRA;
      SH_SLLV: begin
        amt_sel    = AMT_REGB;
        shift_kind = CMD_SLL;
      end
      SH_SRAV: begin
        amt_sel    = AMT_REGB;
        shift_kind = CMD_SRA;
      end
      SH_LUI: begin
        amt_sel    = AMT_16;
        src_sel    = 1'b1;
        shift_kind = CMD_SLL;
      end
      default: begin
        amt_sel = AMT_REGB;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle shift controller: IDLE -> LOAD -> SHIFT -> WB, with an ERR
// detour for illegal opcodes and an optional skip of SHIFT for zero amounts.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter logic [4:0] LUI_AMT   = 5'd16,
  parameter bit         SKIP_ZERO = 1'b1
) (
  input logic             clk,
  input logic             reset,
  shift_sequencer_if.slave bus
);

  state_t     state, state_nxt;
  logic [2:0] op_q;
  logic [2:0] dec_op;
  logic [1:0] dec_amt_sel;
  logic       dec_src_sel;
  logic [2:0] dec_kind;
  logic       dec_illegal;
  logic [4:0] eff_amt;

  // In IDLE the decoder looks at the incoming opcode to pick LOAD vs ERR;
  // IDLE outputs are constants, so only op_q ever reaches the shifter controls.
  assign dec_op = (state == S_IDLE) ? bus.op : op_q;

  shift_op_decode u_decode (
    .op         (dec_op),
    .amt_sel    (dec_amt_sel),
    .src_sel    (dec_src_sel),
    .shift_kind (dec_kind),
    .illegal    (dec_illegal)
  );

  // LUI shifts by the constant, so the mux output is irrelevant to the skip test.
  assign eff_amt = (op_q == SH_LUI) ? LUI_AMT : bus.amt;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      state <= S_IDLE;
      op_q  <= SH_SLL;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && bus.start) begin
        op_q <= bus.op;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.amt_sel   = AMT_REGB;
    bus.src_sel   = 1'b0;
    bus.shift_cmd = CMD_HOLD;
    bus.res_wr    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = dec_illegal ? S_ERR : S_LOAD;
        end
      end
      S_LOAD: begin
        bus.busy      = 1'b1;
        bus.shift_cmd = CMD_LOAD;
        bus.amt_sel   = dec_amt_sel;
        bus.src_sel   = dec_src_sel;
        state_nxt     = (SKIP_ZERO && eff_amt == 5'd0) ? S_WB : S_SHIFT;
      end
      S_SHIFT: begin
        bus.busy      = 1'b1;
        bus.shift_cmd = dec_kind;
        bus.amt_sel   = dec_amt_sel;
        bus.src_sel   = dec_src_sel;
        state_nxt     = S_WB;
      end
      S_WB: begin
        bus.busy    = 1'b1;
        bus.done    = 1'b1;
        bus.res_wr  = 1'b1;
        bus.amt_sel = dec_amt_sel;
        bus.src_sel = dec_src_sel;
        state_nxt   = S_IDLE;
      end
      S_ERR: begin
        bus.err   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: two sequencers (zero-skip on and off) driven in
// lockstep, checked cycle by cycle against a transaction-level model.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] amt_sel;
    logic       src_sel;
    logic [2:0] shift_cmd;
    logic       res_wr;
  } outs_t;

  typedef struct {
    logic [2:0] op;
    logic [4:0] amt;
    int         lat_skip;
    int         lat_noskip;
    int         exp_err;
    int         exp_amt_sel;
    int         exp_src;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  shift_sequencer_if sif_s ();
  shift_sequencer_if sif_n ();

  shift_sequencer #(.LUI_AMT(5'd16), .SKIP_ZERO(1'b1)) dut_skip (
    .clk   (clk),
    .reset (reset),
    .bus   (sif_s)
  );

  shift_sequencer #(.LUI_AMT(5'd16), .SKIP_ZERO(1'b0)) dut_noskip (
    .clk   (clk),
    .reset (reset),
    .bus   (sif_n)
  );

  task automatic check_o(input string name, input outs_t act, input outs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (busy done err sel2 src cmd3 wr)", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic outs_t mk(input bit busy, input bit done, input bit err,
                               input logic [1:0] sel, input bit src,
                               input logic [2:0] cmd, input bit wr);
    outs_t o;
    o.busy = busy; o.done = done; o.err = err; o.amt_sel = sel;
    o.src_sel = src; o.shift_cmd = cmd; o.res_wr = wr;
    return o;
  endfunction

  // Expected outputs 'cyc' clocks after the accepting edge (cyc >= 1).
  function automatic outs_t model_at(input logic [2:0] op, input logic [4:0] amt,
                                     input bit skip, input int cyc);
    logic [1:0] sel;
    logic       src;
    logic [2:0] kind;
    logic [4:0] eff;
    int         last;
    if (op >= 3'd6) begin
      if (cyc == 1) return mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 3'b000, 1'b0);
      return '0;
    end
    sel  = (op == 3'd3 || op == 3'd4) ? 2'b00 : (op == 3'd5) ? 2'b10 : 2'b01;
    src  = (op == 3'd5);
    kind = (op == 3'd1) ? 3'b011 : (op == 3'd2 || op == 3'd4) ? 3'b100 : 3'b010;
    eff  = (op == 3'd5) ? 5'd16 : amt;
    last = (skip && eff == 5'd0) ? 2 : 3;
    if (cyc == 1)    return mk(1'b1, 1'b0, 1'b0, sel, src, 3'b001, 1'b0);
    if (cyc < last)  return mk(1'b1, 1'b0, 1'b0, sel, src, kind, 1'b0);
    if (cyc == last) return mk(1'b1, 1'b1, 1'b0, sel, src, 3'b000, 1'b1);
    return '0;
  endfunction

  function automatic outs_t get_s();
    return mk(sif_s.busy, sif_s.done, sif_s.err, sif_s.amt_sel, sif_s.src_sel,
              sif_s.shift_cmd, sif_s.res_wr);
  endfunction

  function automatic outs_t get_n();
    return mk(sif_n.busy, sif_n.done, sif_n.err, sif_n.amt_sel, sif_n.src_sel,
              sif_n.shift_cmd, sif_n.res_wr);
  endfunction

  task automatic drive(input logic s, input logic [2:0] o, input logic [4:0] a);
    sif_s.start = s; sif_s.op = o; sif_s.amt = a;
    sif_n.start = s; sif_n.op = o; sif_n.amt = a;
  endtask

  // One request from IDLE; 'extra' re-asserts start with junk opcodes while busy.
  task automatic run_txn(input logic [2:0] op, input logic [4:0] amt, input bit extra,
                         input string tag, output int done_s, output int done_n,
                         output int err_s, output outs_t load_s);
    outs_t a, b;
    bit    extra_ok;
    extra_ok = extra && (op <= 3'd5);
    done_s = 0; done_n = 0; err_s = 0; load_s = '0;
    drive(1'b1, op, amt);
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      a = get_s();
      b = get_n();
      check_o($sformatf("%s op=%0d amt=%0d skip c%0d", tag, op, amt, cyc), a, model_at(op, amt, 1'b1, cyc));
      check_o($sformatf("%s op=%0d amt=%0d noskip c%0d", tag, op, amt, cyc), b, model_at(op, amt, 1'b0, cyc));
      if (a.done && done_s == 0) done_s = cyc;
      if (b.done && done_n == 0) done_n = cyc;
      if (a.err) err_s = 1;
      if (cyc == 1) load_s = a;
      drive(extra_ok && cyc <= 2, 3'($urandom_range(7)),
            (cyc == 1) ? amt : 5'($urandom_range(31)));
      @(posedge clk); #1;
    end
  endtask

  vec_t  vecs [9];
  int    ds, dn, es;
  outs_t ls;
  int    late_done;

  initial begin
    vecs[0] = '{3'b000, 5'd5,  3, 3, 0, 1, 0};
    vecs[1] = '{3'b100, 5'd31, 3, 3, 0, 0, 0};
    vecs[2] = '{3'b101, 5'd16, 3, 3, 0, 2, 1};
    vecs[3] = '{3'b001, 5'd0,  2, 3, 0, 1, 0};
    vecs[4] = '{3'b101, 5'd0,  3, 3, 0, 2, 1};
    vecs[5] = '{3'b011, 5'd0,  2, 3, 0, 0, 0};
    vecs[6] = '{3'b010, 5'd1,  3, 3, 0, 1, 0};
    vecs[7] = '{3'b110, 5'd7,  0, 0, 1, 0, 0};
    vecs[8] = '{3'b111, 5'd0,  0, 0, 1, 0, 0};

    reset = 1'b0;
    drive(1'b0, 3'd0, 5'd0);
    #1 reset = 1'b1;
    #1;
    check_o("reset skip", get_s(), '0);
    check_o("reset noskip", get_n(), '0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check_o("idle skip", get_s(), '0);
    check_o("idle noskip", get_n(), '0);

    foreach (vecs[i]) begin
      run_txn(vecs[i].op, vecs[i].amt, (i % 2) == 1, $sformatf("vec%0d", i), ds, dn, es, ls);
      check_i($sformatf("vec%0d done lat skip", i), ds, vecs[i].lat_skip);
      check_i($sformatf("vec%0d done lat noskip", i), dn, vecs[i].lat_noskip);
      check_i($sformatf("vec%0d err", i), es, vecs[i].exp_err);
      check_i($sformatf("vec%0d load amt_sel", i), int'(ls.amt_sel), vecs[i].exp_amt_sel);
      check_i($sformatf("vec%0d load src_sel", i), int'(ls.src_sel), vecs[i].exp_src);
    end

    for (int k = 0; k < 40; k++) begin
      logic [2:0] rop;
      logic [4:0] ramt;
      rop  = 3'($urandom_range(7));
      ramt = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
      run_txn(rop, ramt, $urandom_range(1) == 1, $sformatf("rnd%0d", k), ds, dn, es, ls);
    end

    // Reset in the middle of SHIFT: outputs clear without a clock edge.
    drive(1'b1, SH_SLL, 5'd5);
    @(posedge clk); #1;
    drive(1'b0, SH_SLL, 5'd5);
    @(posedge clk); #1;
    check_i("pre-reset cmd skip", int'(sif_s.shift_cmd), int'(CMD_SLL));
    check_i("pre-reset cmd noskip", int'(sif_n.shift_cmd), int'(CMD_SLL));
    #2 reset = 1'b1;
    #1;
    check_o("async reset skip", get_s(), '0);
    check_o("async reset noskip", get_n(), '0);
    late_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (sif_s.done || sif_n.done || sif_s.res_wr || sif_n.res_wr) late_done++;
    end
    check_i("no done after reset", late_done, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    run_txn(SH_SRA, 5'd9, 1'b0, "post-reset", ds, dn, es, ls);
    check_i("post-reset done skip", ds, 3);
    check_i("post-reset done noskip", dn, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
